// File: rtl/writeback_unit_if.sv
// Writeback-stage bus: memory-stage handoff, data-memory return,
// decode read addresses and the register-file write port.
// Macro WB_FWD_EN adds the decode forwarding signals.
interface writeback_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  inValid;
  logic                  inReady;
  logic                  regWriteIn;
  logic                  memToReg;
  logic [4:0]            destReg;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [1:0]            loadSize;
  logic                  loadSigned;
  logic                  memDataValid;
  logic [DATA_WIDTH-1:0] memData;
  logic [4:0]            reg1;
  logic [4:0]            reg2;
  logic                  regWrite;
  logic [4:0]            writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  hazardStall;
  logic                  memError;
`ifdef WB_FWD_EN
  logic                  fwdHit1;
  logic                  fwdHit2;
  logic [DATA_WIDTH-1:0] fwdData;
`endif

  // Writeback unit side
  modport slave (
    input  inValid, regWriteIn, memToReg, destReg, aluResult, loadSize,
           loadSigned, memDataValid, memData, reg1, reg2,
`ifdef WB_FWD_EN
    output fwdHit1, fwdHit2, fwdData,
`endif
    output inReady, regWrite, writeRegister, writeData, hazardStall, memError
  );

  // Pipeline / environment side
  modport master (
    output inValid, regWriteIn, memToReg, destReg, aluResult, loadSize,
           loadSigned, memDataValid, memData, reg1, reg2,
`ifdef WB_FWD_EN
    input  fwdHit1, fwdHit2, fwdData,
`endif
    input  inReady, regWrite, writeRegister, writeData, hazardStall, memError
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: drives the register-file write port from either
// the ALU result or size-extended load data, waits on variable-latency
// memory returns with a timeout, flags load-use hazards and never writes X31.
// Optional macro WB_FWD_EN adds combinational forwarding outputs for decode.
module writeback_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic            clock,
  input logic            reset,
  writeback_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [4:0]            pend_dest_reg;
  logic                  pend_write_reg;
  logic [1:0]            pend_size_reg;
  logic                  pend_signed_reg;
  logic                  reg_write_reg;
  logic [4:0]            write_reg_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;
  logic                  mem_error_reg;

  logic                  ready;
  logic                  transfer;
  logic                  write_allowed;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [4:0]            rd_addr [2];
  logic [1:0]            rd_match;

  assign ready         = (state_reg == IDLE);
  assign transfer      = bus.inValid && ready;
  // X31 reads as zero, so a write to it is dropped at the source
  assign write_allowed = bus.regWriteIn && (bus.destReg != 5'd31);

  // Size-extend the right-aligned load data using the latched size/sign
  always_comb begin
    ext_data = bus.memData;
    case (pend_size_reg)
      2'b00:   ext_data = {{(DATA_WIDTH-8){pend_signed_reg & bus.memData[7]}},
                           bus.memData[7:0]};
      2'b01:   ext_data = {{(DATA_WIDTH-16){pend_signed_reg & bus.memData[15]}},
                           bus.memData[15:0]};
      default: ext_data = bus.memData;
    endcase
  end

  assign rd_addr[0] = bus.reg1;
  assign rd_addr[1] = bus.reg2;

  // Per-read-port compares against the pending load destination
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_cmp
      assign rd_match[gi] = (rd_addr[gi] == pend_dest_reg);
    end
  endgenerate

  // Main FSM with registered write-port outputs and pending-load bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      pend_dest_reg   <= '0;
      pend_write_reg  <= 1'b0;
      pend_size_reg   <= '0;
      pend_signed_reg <= 1'b0;
      reg_write_reg   <= 1'b0;
      write_reg_reg   <= '0;
      write_data_reg  <= '0;
      mem_error_reg   <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse; address/data hold otherwise
      reg_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            if (!bus.memToReg) begin
              reg_write_reg  <= write_allowed;
              write_reg_reg  <= bus.destReg;
              write_data_reg <= bus.aluResult;
            end else begin
              pend_dest_reg   <= bus.destReg;
              pend_write_reg  <= write_allowed;
              pend_size_reg   <= bus.loadSize;
              pend_signed_reg <= bus.loadSigned;
              count_reg       <= '0;
              state_reg       <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (bus.memDataValid) begin
            reg_write_reg  <= pend_write_reg;
            write_reg_reg  <= pend_dest_reg;
            write_data_reg <= ext_data;
            state_reg      <= IDLE;
          end else if (count_reg == CNT_LAST) begin
            // Memory never answered: drop the load and remember it
            mem_error_reg  <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.inReady       = ready;
  assign bus.regWrite      = reg_write_reg;
  assign bus.writeRegister = write_reg_reg;
  assign bus.writeData     = write_data_reg;
  assign bus.memError      = mem_error_reg;
  assign bus.hazardStall   = (state_reg == WAIT_MEM) && pend_write_reg && (|rd_match);

`ifdef WB_FWD_EN
  logic [1:0] fwd_hit;

  // Bypass the write being committed this cycle to each decode read port
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hit[gi] = reg_write_reg && (write_reg_reg == rd_addr[gi]);
    end
  endgenerate

  assign bus.fwdHit1 = fwd_hit[0];
  assign bus.fwdHit2 = fwd_hit[1];
  assign bus.fwdData = write_data_reg;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed vectors with literal expectations
// plus a transaction-level model compared against the DUT every cycle.
// Honours WB_FWD_EN when defined.
module tb_writeback_unit;

  localparam int DW  = 32;
  localparam int MTO = 16;

  logic clock;
  logic reset;

  writeback_unit_if #(.DATA_WIDTH(DW)) bus ();

  writeback_unit #(.DATA_WIDTH(DW), .MEM_TIMEOUT(MTO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_waiting = 0;
  int        m_elapsed = 0;
  int        m_pdest   = 0;
  bit        m_pwrite  = 0;
  int        m_psize   = 0;
  bit        m_psigned = 0;
  bit        e_regwrite = 0;
  logic [4:0]  e_wreg  = '0;
  logic [31:0] e_wdata = '0;
  bit        e_memerr = 0;

  function automatic logic [31:0] m_extend(input int size, input bit sgn, input logic [31:0] d);
    int     bits;
    longint v;
    bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
    v = longint'({32'd0, d}) & ((64'sd1 <<< bits) - 1);
    if (sgn && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_waiting = 0; m_elapsed = 0; m_pwrite = 0;
      e_regwrite = 0; e_wreg = '0; e_wdata = '0; e_memerr = 0;
    end else begin
      e_regwrite = 0;
      if (!m_waiting) begin
        if (bus.inValid) begin
          if (!bus.memToReg) begin
            e_regwrite = bus.regWriteIn && (int'(bus.destReg) != 31);
            e_wreg     = bus.destReg;
            e_wdata    = bus.aluResult;
          end else begin
            m_waiting = 1;
            m_elapsed = 0;
            m_pdest   = int'(bus.destReg);
            m_pwrite  = bus.regWriteIn && (int'(bus.destReg) != 31);
            m_psize   = int'(bus.loadSize);
            m_psigned = bus.loadSigned;
          end
        end
      end else if (bus.memDataValid) begin
        e_regwrite = m_pwrite;
        e_wreg     = 5'(m_pdest);
        e_wdata    = m_extend(m_psize, m_psigned, bus.memData);
        m_waiting  = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == MTO) begin
          m_waiting = 0;
          e_memerr  = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit e_haz;
    e_haz = m_waiting && m_pwrite &&
            (int'(bus.reg1) == m_pdest || int'(bus.reg2) == m_pdest);
    chk("m_inReady",       bus.inReady,       !m_waiting);
    chk("m_regWrite",      bus.regWrite,      e_regwrite);
    chk("m_writeRegister", bus.writeRegister, e_wreg);
    chk("m_writeData",     bus.writeData,     e_wdata);
    chk("m_memError",      bus.memError,      e_memerr);
    chk("m_hazardStall",   bus.hazardStall,   e_haz);
`ifdef WB_FWD_EN
    chk("m_fwdHit1", bus.fwdHit1, e_regwrite && (e_wreg == bus.reg1));
    chk("m_fwdHit2", bus.fwdHit2, e_regwrite && (e_wreg == bus.reg2));
    chk("m_fwdData", bus.fwdData, e_wdata);
`endif
  endtask

  // Model advances on each edge; outputs are compared shortly after it
  always @(posedge clock) begin
    model_step();
    #2;
    compare_all();
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.inValid      = 1'b0;
    bus.memDataValid = 1'b0;
  endtask

  task automatic issue_alu(input logic [4:0] dest, input logic [31:0] val, input logic wr);
    bus.inValid    = 1'b1;
    bus.memToReg   = 1'b0;
    bus.regWriteIn = wr;
    bus.destReg    = dest;
    bus.aluResult  = val;
  endtask

  task automatic issue_load(input logic [4:0] dest, input logic [1:0] size, input logic sgn);
    bus.inValid    = 1'b1;
    bus.memToReg   = 1'b1;
    bus.regWriteIn = 1'b1;
    bus.destReg    = dest;
    bus.loadSize   = size;
    bus.loadSigned = sgn;
  endtask

  task automatic deliver(input logic [31:0] d);
    bus.memDataValid = 1'b1;
    bus.memData      = d;
  endtask

  logic [1:0]  lv_size [5];
  logic        lv_sgn  [5];
  logic [31:0] lv_data [5];
  logic [31:0] lv_exp  [5];

  initial begin
    int n;
    lv_size[0] = 2'b00; lv_sgn[0] = 1'b0; lv_data[0] = 32'h1234_56F0; lv_exp[0] = 32'h0000_00F0;
    lv_size[1] = 2'b01; lv_sgn[1] = 1'b1; lv_data[1] = 32'hABCD_8001; lv_exp[1] = 32'hFFFF_8001;
    lv_size[2] = 2'b01; lv_sgn[2] = 1'b0; lv_data[2] = 32'hABCD_8001; lv_exp[2] = 32'h0000_8001;
    lv_size[3] = 2'b11; lv_sgn[3] = 1'b1; lv_data[3] = 32'h8000_0001; lv_exp[3] = 32'h8000_0001;
    lv_size[4] = 2'b00; lv_sgn[4] = 1'b1; lv_data[4] = 32'h0000_007F; lv_exp[4] = 32'h0000_007F;

    reset = 1'b0;
    bus.inValid = 1'b0; bus.regWriteIn = 1'b0; bus.memToReg = 1'b0;
    bus.destReg = '0; bus.aluResult = '0; bus.loadSize = '0; bus.loadSigned = 1'b0;
    bus.memDataValid = 1'b0; bus.memData = '0; bus.reg1 = '0; bus.reg2 = '0;
    repeat (3) @(negedge clock);
    $display("reset state: inReady=%0b regWrite=%0b", bus.inReady, bus.regWrite);
    chk("rst_regWrite", bus.regWrite, 0);
    chk("rst_writeRegister", bus.writeRegister, 0);
    chk("rst_writeData", bus.writeData, 0);
    chk("rst_memError", bus.memError, 0);
    chk("rst_inReady", bus.inReady, 1);
    chk("rst_hazardStall", bus.hazardStall, 0);
    reset = 1'b1;

    // ALU path
    @(negedge clock);
    issue_alu(5'd5, 32'h0000_1234, 1'b1);
    @(negedge clock);
    idle_inputs();
    $display("alu write: reg=%0d data=%08h", bus.writeRegister, bus.writeData);
    chk("alu_regWrite", bus.regWrite, 1);
    chk("alu_writeRegister", bus.writeRegister, 5);
    chk("alu_writeData", bus.writeData, 32'h0000_1234);
    @(negedge clock);
    chk("alu_pulse_end", bus.regWrite, 0);
    chk("alu_data_hold", bus.writeData, 32'h0000_1234);

    // Signed byte load, data three cycles later
    issue_load(5'd9, 2'b00, 1'b1);
    @(negedge clock);
    idle_inputs();
    chk("ldb_ready_w1", bus.inReady, 0);
    @(negedge clock);
    chk("ldb_ready_w2", bus.inReady, 0);
    @(negedge clock);
    chk("ldb_ready_w3", bus.inReady, 0);
    deliver(32'h0000_0080);
    @(negedge clock);
    idle_inputs();
    $display("byte load: reg=%0d data=%08h", bus.writeRegister, bus.writeData);
    chk("ldb_regWrite", bus.regWrite, 1);
    chk("ldb_writeRegister", bus.writeRegister, 9);
    chk("ldb_writeData", bus.writeData, 32'hFFFF_FF80);
    chk("ldb_ready_after", bus.inReady, 1);

    // Load-use hazard
    bus.reg1 = 5'd7; bus.reg2 = 5'd0;
    issue_load(5'd7, 2'b10, 1'b0);
    @(negedge clock);
    idle_inputs();
    chk("haz_reg1", bus.hazardStall, 1);
    bus.reg1 = 5'd8; bus.reg2 = 5'd7;
    @(negedge clock);
    chk("haz_reg2", bus.hazardStall, 1);
    deliver(32'h1234_5678);
    @(negedge clock);
    idle_inputs();
    $display("hazard load: reg=%0d data=%08h stall=%0b", bus.writeRegister, bus.writeData, bus.hazardStall);
    chk("haz_word_data", bus.writeData, 32'h1234_5678);
    chk("haz_cleared", bus.hazardStall, 0);
    bus.reg1 = 5'd31;
    issue_load(5'd31, 2'b10, 1'b0);
    @(negedge clock);
    idle_inputs();
    chk("haz_x31", bus.hazardStall, 0);
    deliver(32'hDEAD_BEEF);
    @(negedge clock);
    idle_inputs();
    $display("x31 load: regWrite=%0b", bus.regWrite);
    chk("x31_no_write", bus.regWrite, 0);
    bus.reg1 = 5'd0; bus.reg2 = 5'd0;

    // Extension table, one-cycle memory latency
    for (int i = 0; i < 5; i++) begin
      issue_load(5'(20 + i), lv_size[i], lv_sgn[i]);
      @(negedge clock);
      idle_inputs();
      deliver(lv_data[i]);
      @(negedge clock);
      idle_inputs();
      $display("ext %0d: size=%0d signed=%0b mem=%08h wd=%08h", i, lv_size[i], lv_sgn[i], lv_data[i], bus.writeData);
      chk("ext_regWrite", bus.regWrite, 1);
      chk("ext_writeData", bus.writeData, lv_exp[i]);
    end

    // Data arriving in the final allowed wait cycle still completes
    issue_load(5'd11, 2'b10, 1'b0);
    repeat (MTO) begin
      @(negedge clock);
      idle_inputs();
    end
    deliver(32'hCAFE_0001);
    @(negedge clock);
    idle_inputs();
    $display("late data: regWrite=%0b data=%08h memError=%0b", bus.regWrite, bus.writeData, bus.memError);
    chk("late_regWrite", bus.regWrite, 1);
    chk("late_memError", bus.memError, 0);

    // Timeout
    issue_load(5'd10, 2'b10, 1'b0);
    n = 0;
    do begin
      @(negedge clock);
      idle_inputs();
      n++;
    end while (!bus.inReady && n < 4 * MTO);
    $display("timeout: cycles=%0d memError=%0b regWrite=%0b", n, bus.memError, bus.regWrite);
    chk("to_cycles", n, MTO + 1);
    chk("to_memError", bus.memError, 1);
    chk("to_no_write", bus.regWrite, 0);
    deliver(32'h5555_5555);
    @(negedge clock);
    idle_inputs();
    chk("to_stray_ignored", bus.regWrite, 0);
    @(negedge clock);
    chk("to_sticky", bus.memError, 1);

    // Reset in the second wait cycle
    issue_load(5'd12, 2'b10, 1'b0);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    deliver(32'h7777_7777);
    @(negedge clock);
    idle_inputs();
    $display("reset mid-load: regWrite=%0b inReady=%0b wd=%08h", bus.regWrite, bus.inReady, bus.writeData);
    chk("rml_regWrite", bus.regWrite, 0);
    chk("rml_inReady", bus.inReady, 1);
    chk("rml_writeRegister", bus.writeRegister, 0);
    chk("rml_writeData", bus.writeData, 0);
    chk("rml_memError", bus.memError, 0);

    // Back-to-back ALU writes
    bus.reg2 = 5'd2;
    issue_alu(5'd1, 32'h0000_0011, 1'b1);
    @(negedge clock);
    issue_alu(5'd2, 32'h0000_0022, 1'b1);
    chk("b2b_1_reg", bus.writeRegister, 1);
    chk("b2b_1_we", bus.regWrite, 1);
    @(negedge clock);
    issue_alu(5'd3, 32'h0000_0033, 1'b1);
    chk("b2b_2_reg", bus.writeRegister, 2);
    chk("b2b_2_data", bus.writeData, 32'h0000_0022);
`ifdef WB_FWD_EN
    chk("b2b_fwdHit2", bus.fwdHit2, 1);
    chk("b2b_fwdData", bus.fwdData, 32'h0000_0022);
`endif
    @(negedge clock);
    issue_alu(5'd31, 32'h0000_0099, 1'b1);
    $display("b2b third: reg=%0d data=%08h", bus.writeRegister, bus.writeData);
    chk("b2b_3_reg", bus.writeRegister, 3);
    chk("b2b_3_we", bus.regWrite, 1);
    @(negedge clock);
    issue_alu(5'd4, 32'h0000_0044, 1'b0);
    chk("alu_x31_no_write", bus.regWrite, 0);
    @(negedge clock);
    idle_inputs();
    chk("alu_nowr_no_write", bus.regWrite, 0);
    @(negedge clock);
    chk("idle_no_write", bus.regWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage. Accepts completed instructions from the memory stage and drives the register-file write port: regWrite, writeRegister and writeData.
- Selects between the ALU result and load data. Load data is size-extended.
- Waits on variable-latency data-memory returns, with a timeout.
- Flags load-use hazards to decode.
- Suppresses writes to X31 (XZR).

Parameters:
- DATA_WIDTH, 32, width of ALU result, memory data and writeData.
- MEM_TIMEOUT, 16, maximum cycles spent in WAIT_MEM before the load is abandoned (must be at least 2).

Ports:
- clock  input  1  main clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- inValid  input  1  memory stage presents an instruction.
- inReady  output  1  unit accepts an instruction this cycle.
- regWriteIn  input  1  instruction writes a register.
- memToReg  input  1  1 = result comes from a load, 0 = from ALU.
- destReg  input  5  destination register address.
- aluResult  input  DATA_WIDTH  ALU result.
- loadSize  input  2  00 = byte, 01 = half, 10 = word, 11 = word.
- loadSigned  input  1  sign-extend (1) or zero-extend (0) load data.
- memDataValid  input  1  data memory returns read data.
- memData  input  DATA_WIDTH  read data, right-aligned.
- reg1  input  5  decode read address 1, used for hazard check.
- reg2  input  5  decode read address 2, used for hazard check.
- regWrite  output  1  register-file write enable.
- writeRegister  output  5  register-file write address.
- writeData  output  DATA_WIDTH  register-file write data.
- hazardStall  output  1  decode must stall (load-use).
- memError  output  1  sticky load-timeout flag.

Behaviour:
- States: IDLE, WAIT_MEM.
- inReady = (state == IDLE). The transfer condition is inValid && inReady.
- IDLE, transfer with memToReg = 0:
  - Next edge: regWrite = regWriteIn && (destReg != 31), writeRegister = destReg, writeData = aluResult.
  - Latency is 1 cycle. Back-to-back transfers sustain one write per cycle.
- IDLE, transfer with memToReg = 1:
  - Latch pendReg = destReg, pendWrite = regWriteIn && (destReg != 31), and the size and signed fields.
  - Clear the timeout counter and go to WAIT_MEM.
  - regWrite = 0 next cycle.
- WAIT_MEM with memDataValid = 1:
  - Next edge: regWrite = pendWrite, writeRegister = pendReg, writeData = extended memData. Return to IDLE.
  - Extension: byte uses memData[7:0], half uses [15:0], word uses all bits. Fill with the top bit of the selected field if loadSigned = 1, else with zeros.
- WAIT_MEM without data: counter increments each cycle. At counter == MEM_TIMEOUT-1 with no data:
  - Go to IDLE with no write.
  - Set memError = 1; it stays set until reset.
- memDataValid while in IDLE is ignored.
- regWrite is a single-cycle pulse per write. writeRegister and writeData hold their last values when regWrite = 0.
- hazardStall is combinational: (state == WAIT_MEM) && pendWrite && ((reg1 == pendReg) || (reg2 == pendReg)).
- Reset, including mid-WAIT_MEM:
  - Go to IDLE and abandon any pending load (no write).
  - regWrite = 0, writeRegister = 0, writeData = 0, memError = 0, counter = 0, pendWrite = 0.
  - Consequently inReady = 1 and hazardStall = 0.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds these ports:
  - fwdHit1 output 1, fwdHit2 output 1, fwdData output DATA_WIDTH.
  - fwdHitN = regWrite && (writeRegister == regN). fwdData = writeData. All combinational.
- Purpose: decode can bypass a same-edge write that its register-file read would otherwise miss.
- When undefined, these ports and the logic do not exist, and all other behaviour is unchanged.

Test Plan:
- ALU path: transfer destReg = 5, aluResult = 0x0000_1234, regWriteIn = 1, memToReg = 0 -> next cycle regWrite = 1, writeRegister = 5, writeData = 0x0000_1234. Following cycle regWrite = 0.
- Signed byte load: memToReg = 1, destReg = 9, loadSize = 00, loadSigned = 1. memData = 0x0000_0080 arrives 3 cycles later -> inReady = 0 throughout the wait. Write of 0xFFFF_FF80 to reg 9 one cycle after memDataValid, then inReady = 1.
- Load-use hazard: load pending to destReg = 7, reg1 = 7 -> hazardStall = 1. With reg1 = 8 and reg2 = 7 -> still 1. After the write -> 0. A load to destReg = 31 gives hazardStall = 0 and no write.
- Timeout: load issued and memDataValid is never asserted -> after 16 cycles state returns to IDLE, no regWrite, memError = 1 and it stays set. A later memDataValid pulse has no effect.
- Reset mid-load: assert reset in the 2nd WAIT_MEM cycle, then deliver memData -> no write, inReady = 1, all outputs 0.
- Back-to-back ALU ops to regs 1, 2, 3 on consecutive cycles -> three consecutive regWrite pulses with matching addresses and data. With WB_FWD_EN and reg2 = 2 -> fwdHit2 = 1 in the cycle reg 2 is written.
